// File: rtl/rle_dec_if.sv
// Run-word input / byte output port bundle for the run-length decoder.
// The slave modport is the decoder side; master is the FIFO/environment side.
interface rle_dec_if #(
  parameter int COUNT_W = 23,
  parameter int BYTE_W  = 8
);
  logic               recv_ready;
  logic [COUNT_W:0]   in_data;
  logic               end_of_stream;
  logic               send_ready;
  logic               rd_req;
  logic [BYTE_W-1:0]  out_data;
  logic               wr_req;
  logic               done;
  logic               pad_err;
  logic               len_err;

  modport master (
    output recv_ready, in_data, end_of_stream, send_ready,
    input  rd_req, out_data, wr_req, done, pad_err, len_err
  );

  modport slave (
    input  recv_ready, in_data, end_of_stream, send_ready,
    output rd_req, out_data, wr_req, done, pad_err, len_err
  );
endinterface

// File: rtl/rle_dec.sv
// Run-length decoder: expands {bit, length} run words into an MSB-first byte stream.
// Latency: word pop to first shifted bit 2 cycles; byte complete to wr_req 1 cycle min; stalls on send_ready.
module rle_dec #(
  parameter int COUNT_W = 23,
  parameter int BYTE_W  = 8
) (
  input logic     clk,
  input logic     rst,
  rle_dec_if.slave bus
);
  localparam int CNT_W = $clog2(BYTE_W + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BYTE_W);

  typedef enum logic [2:0] {IDLE, LATCH, EXPAND, WRITE, FLUSH, DONE} state_t;

  state_t             state, state_nxt;
  logic [BYTE_W-1:0]  shreg, out_hold, wr_dat;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_inc;
  logic [COUNT_W-1:0] run_left, run_left_dec, in_len;
  logic               run_bit, in_bit;
  logic               rd_req_c, wr_req_c;
  logic               pad_err, len_err;

  assign in_bit       = bus.in_data[COUNT_W];
  assign in_len       = bus.in_data[COUNT_W-1:0];
  assign bit_cnt_inc  = bit_cnt + CNT_W'(1);
  assign run_left_dec = (run_left != '0) ? run_left - COUNT_W'(1) : run_left;

  always_comb begin
    state_nxt = state;
    rd_req_c  = 1'b0;
    wr_req_c  = 1'b0;
    wr_dat    = shreg;
    case (state)
      IDLE: begin
        if (bus.recv_ready) begin
          rd_req_c  = 1'b1;
          state_nxt = LATCH;
        end else if (bus.end_of_stream) begin
          state_nxt = (bit_cnt != '0) ? FLUSH : DONE;
        end
      end
      LATCH:  state_nxt = (in_len == '0) ? IDLE : EXPAND;
      EXPAND: begin
        // A byte boundary takes precedence; the rest of the run resumes after the write.
        if (bit_cnt_inc == FULL)
          state_nxt = WRITE;
        else if (run_left_dec == '0)
          state_nxt = IDLE;
      end
      WRITE: begin
        if (bus.send_ready) begin
          wr_req_c  = 1'b1;
          state_nxt = (run_left != '0) ? EXPAND : IDLE;
        end
      end
      FLUSH: begin
        wr_dat = shreg << (FULL - bit_cnt);
        if (bus.send_ready) begin
          wr_req_c  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      out_hold <= '0;
      bit_cnt  <= '0;
      run_left <= '0;
      run_bit  <= 1'b0;
      pad_err  <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      case (state)
        LATCH: begin
          run_bit  <= in_bit;
          run_left <= in_len;
          if (in_len == '0) len_err <= 1'b1;
        end
        EXPAND: begin
          shreg    <= {shreg[BYTE_W-2:0], run_bit};
          bit_cnt  <= bit_cnt_inc;
          run_left <= run_left_dec;
        end
        FLUSH: if (wr_req_c) pad_err <= 1'b1;
        default: ;
      endcase
      if (wr_req_c) begin
        out_hold <= wr_dat;
        bit_cnt  <= '0;
      end
    end
  end

  // Requests are Mealy outputs; gate them so reset forces them low immediately.
  assign bus.rd_req   = rd_req_c & ~rst;
  assign bus.wr_req   = wr_req_c & ~rst;
  assign bus.out_data = bus.wr_req ? wr_dat : out_hold;
  assign bus.done     = (state == DONE);
  assign bus.pad_err  = pad_err;
  assign bus.len_err  = len_err;
endmodule

// File: tb/tb_rle_dec.sv
// Directed bench for rle_dec: word-queue input FIFO model, captured output bytes vs hand-computed values.
module tb_rle_dec;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rle_dec_if #(.COUNT_W(23), .BYTE_W(8)) bus();
  rle_dec #(.COUNT_W(23), .BYTE_W(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int vectors    = 0;
  int miscompares = 0;
  int viol       = 0;
  logic [23:0] wq[$];
  logic [7:0]  got[$];

  // Advance n cycles: FIFO model answers rd_req with the next word one cycle later.
  task automatic cycles(input int n, input bit stall);
    logic popped;
    for (int i = 0; i < n; i++) begin
      bus.recv_ready = (wq.size() != 0);
      bus.send_ready = stall ? i[0] : 1'b1;
      @(negedge clk);
      if (bus.rd_req && bus.wr_req) viol++;
      if (bus.wr_req && !bus.send_ready) viol++;
      if (bus.rd_req && !bus.recv_ready) viol++;
      if (bus.wr_req) got.push_back(bus.out_data);
      popped = bus.rd_req;
      @(posedge clk); #1;
      if (popped && wq.size() != 0) bus.in_data = wq.pop_front();
    end
  endtask

  task automatic test_reset;
    bus.recv_ready    = 1'b1;
    bus.in_data       = 24'h800008;
    bus.end_of_stream = 1'b0;
    bus.send_ready    = 1'b1;
    rst = 1'b1;
    #12;
    vectors++; if (bus.rd_req !== 1'b0) begin miscompares++; $display("FAIL reset_rd_req got=%b exp=0", bus.rd_req); end
    vectors++; if (bus.wr_req !== 1'b0) begin miscompares++; $display("FAIL reset_wr_req got=%b exp=0", bus.wr_req); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    vectors++; if (bus.pad_err !== 1'b0) begin miscompares++; $display("FAIL reset_pad_err got=%b exp=0", bus.pad_err); end
    vectors++; if (bus.len_err !== 1'b0) begin miscompares++; $display("FAIL reset_len_err got=%b exp=0", bus.len_err); end
    vectors++; if (bus.out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
    bus.recv_ready = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_pack;
    got.delete();
    wq.push_back(24'h000002); wq.push_back(24'h800004); wq.push_back(24'h000002);
    cycles(25, 1'b0);
    vectors++; if (got.size() !== 1) begin miscompares++; $display("FAIL pack_count got=%0d exp=1", got.size()); end
    else begin vectors++; if (got[0] !== 8'h3C) begin miscompares++; $display("FAIL pack_byte got=%h exp=3c", got[0]); end end
    vectors++; if (bus.len_err !== 1'b0 || bus.pad_err !== 1'b0) begin miscompares++; $display("FAIL pack_flags got=%b%b exp=00", bus.len_err, bus.pad_err); end
  endtask

  task automatic test_span;
    got.delete();
    wq.push_back(24'h80000C); wq.push_back(24'h000004);
    cycles(35, 1'b0);
    vectors++; if (got.size() !== 2) begin miscompares++; $display("FAIL span_count got=%0d exp=2", got.size()); end
    else begin
      vectors++; if (got[0] !== 8'hFF) begin miscompares++; $display("FAIL span_byte0 got=%h exp=ff", got[0]); end
      vectors++; if (got[1] !== 8'hF0) begin miscompares++; $display("FAIL span_byte1 got=%h exp=f0", got[1]); end
    end
  endtask

  task automatic test_stall;
    got.delete();
    viol = 0;
    wq.push_back(24'h000018);
    cycles(60, 1'b1);
    vectors++; if (got.size() !== 3) begin miscompares++; $display("FAIL stall_count got=%0d exp=3", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      vectors++; if (got[k] !== 8'h00) begin miscompares++; $display("FAIL stall_byte%0d got=%h exp=00", k, got[k]); end
    end
    vectors++; if (viol !== 0) begin miscompares++; $display("FAIL stall_handshake got=%0d violations exp=0", viol); end
  endtask

  task automatic test_len_err;
    got.delete();
    wq.push_back(24'h800000); wq.push_back(24'h800008);
    cycles(25, 1'b0);
    vectors++; if (bus.len_err !== 1'b1) begin miscompares++; $display("FAIL len_err_flag got=%b exp=1", bus.len_err); end
    vectors++; if (got.size() !== 1) begin miscompares++; $display("FAIL len_err_count got=%0d exp=1", got.size()); end
    else begin vectors++; if (got[0] !== 8'hFF) begin miscompares++; $display("FAIL len_err_byte got=%h exp=ff", got[0]); end end
  endtask

  task automatic test_reset_mid;
    got.delete();
    wq.push_back(24'h800008);
    cycles(6, 1'b0);
    rst = 1'b1;
    #1;
    vectors++; if (bus.len_err !== 1'b0) begin miscompares++; $display("FAIL midrst_len_err got=%b exp=0", bus.len_err); end
    vectors++; if (bus.out_data !== 8'h00) begin miscompares++; $display("FAIL midrst_out_data got=%h exp=00", bus.out_data); end
    vectors++; if (bus.wr_req !== 1'b0 || bus.rd_req !== 1'b0 || bus.done !== 1'b0 || bus.pad_err !== 1'b0) begin
      miscompares++; $display("FAIL midrst_ctrl got=%b%b%b%b exp=0000", bus.wr_req, bus.rd_req, bus.done, bus.pad_err); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    wq.push_back(24'h000008);
    cycles(20, 1'b0);
    vectors++; if (got.size() !== 1) begin miscompares++; $display("FAIL midrst_count got=%0d exp=1", got.size()); end
    else begin vectors++; if (got[0] !== 8'h00) begin miscompares++; $display("FAIL midrst_byte got=%h exp=00", got[0]); end end
  endtask

  task automatic test_flush;
    got.delete();
    wq.push_back(24'h800003);
    cycles(10, 1'b0);
    vectors++; if (got.size() !== 0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL flush_pre got=%0d/%b exp=0/0", got.size(), bus.done); end
    bus.end_of_stream = 1'b1;
    cycles(6, 1'b0);
    vectors++; if (got.size() !== 1) begin miscompares++; $display("FAIL flush_count got=%0d exp=1", got.size()); end
    else begin vectors++; if (got[0] !== 8'hE0) begin miscompares++; $display("FAIL flush_byte got=%h exp=e0", got[0]); end end
    vectors++; if (bus.pad_err !== 1'b1) begin miscompares++; $display("FAIL flush_pad_err got=%b exp=1", bus.pad_err); end
    vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL flush_done got=%b exp=1", bus.done); end
    wq.push_back(24'h800008);
    cycles(15, 1'b0);
    vectors++; if (wq.size() !== 1 || got.size() !== 1) begin miscompares++; $display("FAIL done_ignores got=%0d words/%0d bytes exp=1/1", wq.size(), got.size()); end
  endtask

  initial begin
    test_reset();
    test_pack();
    test_span();
    test_stall();
    test_len_err();
    test_reset_mid();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
